conv_ctrl_seq: RTL and testbench

//   Parametrised control FSM for the conv layer datapath. Sequences address,

---
 rtl/conv_ctrl_seq_if.sv | 40 ++++
 rtl/conv_ctrl_seq.sv | 189 ++++++++++++++++++
 tb/tb_conv_ctrl_seq.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_ctrl_seq_if.sv
// Control bus between the conv layer top/datapath and the conv_ctrl_seq sequencer.
// The master modport is the sequencer side; the slave modport is the layer/datapath side.
interface conv_ctrl_seq_if #(
  parameter int unsigned KROWS = 3,
  parameter int unsigned NCH   = 1,
  parameter int unsigned OUT_W = 26,
  parameter int unsigned OUT_H = 26
);
  localparam int unsigned SELW = $clog2(KROWS + 1);
  localparam int unsigned RW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int unsigned CW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned NW   = (NCH > 1) ? $clog2(NCH) : 1;

  logic            start;
  logic            store_ready;
  logic            busy;
  logic            done;
  logic            addr;
  logic            load;
  logic [SELW-1:0] mux_sel;
  logic            flush_acc;
  logic            acc_enable;
  logic            store;
  logic            counter_enable;
  logic [RW-1:0]   out_row;
  logic [CW-1:0]   out_col;
  logic [NW-1:0]   ch_idx;

  modport master (
    input  start, store_ready,
    output busy, done, addr, load, mux_sel, flush_acc, acc_enable,
           store, counter_enable, out_row, out_col, ch_idx
  );

  modport slave (
    output start, store_ready,
    input  busy, done, addr, load, mux_sel, flush_acc, acc_enable,
           store, counter_enable, out_row, out_col, ch_idx
  );
endinterface

// File: rtl/conv_ctrl_seq.sv
// Conv layer control sequencer: walks every output pixel through address, load,
// KROWS MAC phases, sum and accumulate per input channel, then stores with backpressure.
module conv_ctrl_seq #(
  parameter int unsigned KROWS = 3,
  parameter int unsigned NCH   = 1,
  parameter int unsigned OUT_W = 26,
  parameter int unsigned OUT_H = 26
) (
  input  logic           clk,
  input  logic           rst,
  conv_ctrl_seq_if.master bus
);
  localparam int unsigned SELW = $clog2(KROWS + 1);
  localparam int unsigned KW   = (KROWS > 1) ? $clog2(KROWS) : 1;
  localparam int unsigned RW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int unsigned CW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned NW   = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_LOAD,
    S_MAC,
    S_SUM,
    S_ACC,
    S_STORE,
    S_UPDATE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          state;
  logic [KW-1:0]   k_q;
  logic            last_q;

  logic            busy_q;
  logic            done_q;
  logic            addr_q;
  logic            load_q;
  logic [SELW-1:0] mux_q;
  logic            flush_q;
  logic            acc_q;
  logic            store_q;
  logic            cen_q;
  logic [RW-1:0]   row_q;
  logic [CW-1:0]   col_q;
  logic [NW-1:0]   ch_q;

  // Outputs are registered alongside the state: each branch loads the strobes
  // that belong to the state being entered, so they line up with that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      k_q     <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= 1'b0;
      load_q  <= 1'b0;
      mux_q   <= '0;
      flush_q <= 1'b0;
      acc_q   <= 1'b0;
      store_q <= 1'b0;
      cen_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      ch_q    <= '0;
    end else begin
      done_q  <= 1'b0;
      addr_q  <= 1'b0;
      load_q  <= 1'b0;
      mux_q   <= '0;
      flush_q <= 1'b0;
      acc_q   <= 1'b0;
      store_q <= 1'b0;
      cen_q   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state   <= S_ADDR;
            busy_q  <= 1'b1;
            addr_q  <= 1'b1;
            flush_q <= (ch_q == '0);
          end
        end

        S_ADDR: begin
          state  <= S_LOAD;
          load_q <= 1'b1;
        end

        S_LOAD: begin
          state <= S_MAC;
          k_q   <= '0;
          mux_q <= SELW'(1);
        end

        // One cycle per kernel row; mux_sel tracks the phase being entered.
        S_MAC: begin
          if (k_q != KW'(KROWS - 1)) begin
            k_q   <= k_q + KW'(1);
            mux_q <= SELW'(k_q) + SELW'(2);
          end else begin
            state <= S_SUM;
          end
        end

        S_SUM: begin
          state <= S_ACC;
          acc_q <= 1'b1;
        end

        // Later channels of the same pixel skip the accumulator flush.
        S_ACC: begin
          if (ch_q != NW'(NCH - 1)) begin
            ch_q   <= ch_q + NW'(1);
            state  <= S_ADDR;
            addr_q <= 1'b1;
          end else begin
            ch_q    <= '0;
            state   <= S_STORE;
            store_q <= 1'b1;
          end
        end

        S_STORE: begin
          if (bus.store_ready) begin
            state <= S_UPDATE;
            cen_q <= 1'b1;
          end else begin
            store_q <= 1'b1;
          end
        end

        S_UPDATE: begin
          state <= S_CHECK;
          if (col_q == CW'(OUT_W - 1)) begin
            col_q <= '0;
            if (row_q == RW'(OUT_H - 1)) begin
              row_q  <= '0;
              last_q <= 1'b1;
            end else begin
              row_q <= row_q + RW'(1);
            end
          end else begin
            col_q <= col_q + CW'(1);
          end
        end

        S_CHECK: begin
          if (last_q) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end else begin
            state   <= S_ADDR;
            addr_q  <= 1'b1;
            flush_q <= (ch_q == '0);
          end
        end

        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          last_q <= 1'b0;
        end

        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          last_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.addr           = addr_q;
  assign bus.load           = load_q;
  assign bus.mux_sel        = mux_q;
  assign bus.flush_acc      = flush_q;
  assign bus.acc_enable     = acc_q;
  assign bus.store          = store_q;
  assign bus.counter_enable = cen_q;
  assign bus.out_row        = row_q;
  assign bus.out_col        = col_q;
  assign bus.ch_idx         = ch_q;
endmodule

// File: tb/tb_conv_ctrl_seq.sv
// Bench for conv_ctrl_seq: a loop-based pixel/channel schedule model predicts every
// output each cycle for two configurations; literal latencies and counts pin the model.
module tb_conv_ctrl_seq;
  typedef struct {
    int busy; int done; int addr; int load; int mux; int flush;
    int acc; int store; int cen; int row; int col; int ch;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  exp_t ex  [2];
  exp_t got [2];
  int   done_cyc [2];
  int   done_cnt [2];
  int   hs_cnt   [2];
  int   acc_cnt  [2];
  int   rdy      [2];

  conv_ctrl_seq_if #(.KROWS(3), .NCH(1), .OUT_W(2), .OUT_H(2)) bus_a ();
  conv_ctrl_seq_if #(.KROWS(2), .NCH(3), .OUT_W(3), .OUT_H(2)) bus_b ();

  conv_ctrl_seq #(.KROWS(3), .NCH(1), .OUT_W(2), .OUT_H(2)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  conv_ctrl_seq #(.KROWS(2), .NCH(3), .OUT_W(3), .OUT_H(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t idle_e();
    exp_t e;
    e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    return e;
  endfunction

  task automatic chk(input string nm, input int d, input int g, input int e);
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc %0d: got %0d, expected %0d", nm, d, cyc, g, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int d, input bit v);
    if (d == 0) bus_a.start = v;
    else        bus_b.start = v;
  endtask

  task automatic set_rdy(input int d, input bit v);
    if (d == 0) bus_a.store_ready = v;
    else        bus_b.store_ready = v;
  endtask

  // Per-cycle compare of both DUTs against the model's current expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      got[0] = '{int'(bus_a.busy), int'(bus_a.done), int'(bus_a.addr), int'(bus_a.load),
                 int'(bus_a.mux_sel), int'(bus_a.flush_acc), int'(bus_a.acc_enable),
                 int'(bus_a.store), int'(bus_a.counter_enable), int'(bus_a.out_row),
                 int'(bus_a.out_col), int'(bus_a.ch_idx)};
      got[1] = '{int'(bus_b.busy), int'(bus_b.done), int'(bus_b.addr), int'(bus_b.load),
                 int'(bus_b.mux_sel), int'(bus_b.flush_acc), int'(bus_b.acc_enable),
                 int'(bus_b.store), int'(bus_b.counter_enable), int'(bus_b.out_row),
                 int'(bus_b.out_col), int'(bus_b.ch_idx)};
      rdy[0] = int'(bus_a.store_ready);
      rdy[1] = int'(bus_b.store_ready);
      for (int d = 0; d < 2; d++) begin
        chk("busy",      d, got[d].busy,  ex[d].busy);
        chk("done",      d, got[d].done,  ex[d].done);
        chk("addr",      d, got[d].addr,  ex[d].addr);
        chk("load",      d, got[d].load,  ex[d].load);
        chk("mux_sel",   d, got[d].mux,   ex[d].mux);
        chk("flush_acc", d, got[d].flush, ex[d].flush);
        chk("acc_en",    d, got[d].acc,   ex[d].acc);
        chk("store",     d, got[d].store, ex[d].store);
        chk("cnt_en",    d, got[d].cen,   ex[d].cen);
        chk("out_row",   d, got[d].row,   ex[d].row);
        chk("out_col",   d, got[d].col,   ex[d].col);
        chk("ch_idx",    d, got[d].ch,    ex[d].ch);
        if (got[d].done != 0) begin
          done_cyc[d] = cyc;
          done_cnt[d]++;
        end
        if (got[d].store != 0 && rdy[d] != 0) hs_cnt[d]++;
        if (got[d].acc != 0) acc_cnt[d]++;
      end
    end
  end

  // Expected schedule: raster over pixels, channels inside each pixel, store
  // held through any stall, then counter advance and a check cycle.
  task automatic run_layer(input int d, input int kr, input int nch, input int w, input int h,
                           input int stall_pix, input int stall_n, input bit poke,
                           output int lat);
    exp_t e;
    int   start_c;
    int   n;
    done_cnt[d] = 0;
    hs_cnt[d]   = 0;
    acc_cnt[d]  = 0;
    done_cyc[d] = -1;
    start_c     = cyc;
    set_start(d, 1'b1);
    ex[d] = idle_e();
    tick();
    set_start(d, 1'b0);
    for (int p = 0; p < w * h; p++) begin
      e = idle_e();
      e.busy = 1;
      e.row  = p / w;
      e.col  = p % w;
      for (int c = 0; c < nch; c++) begin
        e.ch    = c;
        e.addr  = 1;
        e.flush = (c == 0) ? 1 : 0;
        set_start(d, poke && p == 1 && c == 0);
        ex[d] = e;
        tick();
        set_start(d, 1'b0);
        e.addr  = 0;
        e.flush = 0;
        e.load  = 1;
        ex[d] = e;
        tick();
        e.load = 0;
        for (int k = 0; k < kr; k++) begin
          e.mux = k + 1;
          ex[d] = e;
          tick();
        end
        e.mux = 0;
        ex[d] = e;
        tick();
        e.acc = 1;
        ex[d] = e;
        tick();
        e.acc = 0;
      end
      e.ch    = 0;
      e.store = 1;
      n = (p == stall_pix) ? stall_n : 0;
      for (int s = 0; s <= n; s++) begin
        set_rdy(d, s == n);
        ex[d] = e;
        tick();
      end
      e.store = 0;
      e.cen   = 1;
      ex[d] = e;
      tick();
      e.cen = 0;
      e.row = ((p + 1) / w) % h;
      e.col = (p + 1) % w;
      ex[d] = e;
      tick();
    end
    e = idle_e();
    e.busy = 1;
    e.done = 1;
    ex[d] = e;
    tick();
    ex[d] = idle_e();
    lat = (done_cyc[d] < 0) ? -1 : done_cyc[d] - start_c;
  endtask

  initial begin
    int   lat;
    exp_t e;
    rst               = 1'b1;
    bus_a.start       = 1'b0;
    bus_b.start       = 1'b0;
    bus_a.store_ready = 1'b1;
    bus_b.store_ready = 1'b1;
    ex[0] = idle_e();
    ex[1] = idle_e();
    done_cyc[0] = -1;
    done_cyc[1] = -1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // 2x2 map, one channel, three kernel rows
    run_layer(0, 3, 1, 2, 2, -1, 0, 1'b0, lat);
    chk("lat_basic",  0, lat, 41);
    chk("stores_2x2", 0, hs_cnt[0], 4);
    chk("accs_2x2",   0, acc_cnt[0], 4);
    chk("dones_2x2",  0, done_cnt[0], 1);

    // Back-to-back layer: 5-cycle store stall on pixel 2, start poked while busy
    run_layer(0, 3, 1, 2, 2, 2, 5, 1'b1, lat);
    chk("lat_stall",    0, lat, 46);
    chk("stores_stall", 0, hs_cnt[0], 4);
    chk("dones_stall",  0, done_cnt[0], 1);
    tick();
    tick();

    // 3x2 map, three channels, two kernel rows
    run_layer(1, 2, 3, 3, 2, -1, 0, 1'b0, lat);
    chk("lat_nch3",    1, lat, 127);
    chk("accs_nch3",   1, acc_cnt[1], 18);
    chk("stores_nch3", 1, hs_cnt[1], 6);
    chk("dones_nch3",  1, done_cnt[1], 1);
    tick();

    // Reset during the first MAC phase aborts without a done pulse
    done_cnt[0] = 0;
    set_start(0, 1'b1);
    ex[0] = idle_e();
    tick();
    set_start(0, 1'b0);
    e = idle_e();
    e.busy  = 1;
    e.addr  = 1;
    e.flush = 1;
    ex[0] = e;
    tick();
    e.addr  = 0;
    e.flush = 0;
    e.load  = 1;
    ex[0] = e;
    tick();
    e.load = 0;
    e.mux  = 1;
    ex[0] = e;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ex[0] = idle_e();
    repeat (6) tick();
    chk("no_done_rst", 0, done_cnt[0], 0);

    // Recovery after the abort
    run_layer(0, 3, 1, 2, 2, -1, 0, 1'b0, lat);
    chk("lat_after_rst", 0, lat, 41);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
